// File: rtl/meas_seq_ctrl.sv
// meas_seq_ctrl: multi-shot measurement sequencer (FIFO reset window, TX, RE, inter-shot gap).
// Optional TX/RE phase timeout is built when MEAS_SEQ_TIMEOUT_EN is defined.
module meas_seq_ctrl #(
  parameter int NUM_SHOTS = 4,
  parameter int RST_DLY   = 100,
  parameter int RST_LEN   = 100,
  parameter int RST_TAIL  = 800,
  parameter int GAP_LEN   = 1000,
  parameter int TIMEOUT   = 65535
) (
  input  logic       clk_100,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       tx_done,
  input  logic       re_done,
  output logic       en_tx,
  output logic       en_re,
  output logic       fifo_rst,
  output logic       busy,
  output logic       done,
  output logic       aborted,
  output logic       err_timeout,
  output logic [7:0] shot_idx,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RST  = 3'd1,
    S_TX   = 3'd2,
    S_RE   = 3'd3,
    S_GAP  = 3'd4,
    S_DONE = 3'd5
  } state_t;

  localparam logic [19:0] FIFO_RST_LO = 20'(RST_DLY);
  localparam logic [19:0] FIFO_RST_HI = 20'(RST_DLY + RST_LEN - 1);
  localparam logic [19:0] RST_LAST    = 20'(RST_DLY + RST_LEN + RST_TAIL - 1);
  localparam logic [19:0] GAP_LAST    = 20'(GAP_LEN - 1);
  localparam logic [19:0] TO_LAST     = 20'(TIMEOUT - 1);
  localparam logic [7:0]  SHOT_LAST   = 8'(NUM_SHOTS - 1);

`ifdef MEAS_SEQ_TIMEOUT_EN
  localparam bit TIMEOUT_ON = 1'b1;
`else
  localparam bit TIMEOUT_ON = 1'b0;
`endif

  state_t      state_reg, state_next;
  logic [19:0] cnt_reg, cnt_next;
  logic [7:0]  shot_idx_reg, shot_idx_next;
  logic        en_tx_reg, en_re_reg, fifo_rst_reg, busy_reg, done_reg, aborted_reg;
  logic        abort_evt, timeout_evt;

  // Next-state logic; stop overrides everything once a run is active.
  always_comb begin
    state_next    = state_reg;
    shot_idx_next = shot_idx_reg;
    timeout_evt   = 1'b0;
    abort_evt     = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (start && !stop) begin
          state_next    = S_RST;
          shot_idx_next = 8'd0;
        end
      end
      S_RST: begin
        if (cnt_reg == RST_LAST) begin
          state_next = S_TX;
        end
      end
      S_TX: begin
        if (tx_done) begin
          state_next = S_RE;
        end else if (TIMEOUT_ON && (cnt_reg == TO_LAST)) begin
          timeout_evt = 1'b1;
          state_next  = S_IDLE;
        end
      end
      S_RE: begin
        if (re_done) begin
          state_next = (shot_idx_reg == SHOT_LAST) ? S_DONE : S_GAP;
        end else if (TIMEOUT_ON && (cnt_reg == TO_LAST)) begin
          timeout_evt = 1'b1;
          state_next  = S_IDLE;
        end
      end
      S_GAP: begin
        if (cnt_reg == GAP_LAST) begin
          state_next    = S_RST;
          shot_idx_next = shot_idx_reg + 8'd1;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase

    if ((state_reg != S_IDLE) && stop) begin
      state_next    = S_IDLE;
      shot_idx_next = shot_idx_reg;
      timeout_evt   = 1'b0;
    end

    abort_evt = ((state_reg != S_IDLE) && stop) || timeout_evt;
  end

  // Phase counter restarts on every state change and only runs in timed states.
  always_comb begin
    cnt_next = 20'd0;
    if (state_next == state_reg) begin
      case (state_reg)
        S_RST, S_TX, S_RE, S_GAP: cnt_next = cnt_reg + 20'd1;
        default:                  cnt_next = 20'd0;
      endcase
    end
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk_100) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      cnt_reg      <= 20'd0;
      shot_idx_reg <= 8'd0;
      en_tx_reg    <= 1'b0;
      en_re_reg    <= 1'b0;
      fifo_rst_reg <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      aborted_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      shot_idx_reg <= shot_idx_next;
      en_tx_reg    <= (state_next == S_TX);
      en_re_reg    <= (state_next == S_RE);
      fifo_rst_reg <= (state_next == S_RST) && (cnt_next >= FIFO_RST_LO) &&
                      (cnt_next <= FIFO_RST_HI);
      busy_reg     <= (state_next != S_IDLE);
      done_reg     <= (state_next == S_DONE);
      aborted_reg  <= abort_evt;
    end
  end

`ifdef MEAS_SEQ_TIMEOUT_EN
  logic err_timeout_reg;

  // Sticky until the next accepted start.
  always_ff @(posedge clk_100) begin
    if (rst) begin
      err_timeout_reg <= 1'b0;
    end else if ((state_reg == S_IDLE) && (state_next == S_RST)) begin
      err_timeout_reg <= 1'b0;
    end else if (timeout_evt) begin
      err_timeout_reg <= 1'b1;
    end
  end

  assign err_timeout = err_timeout_reg;
`else
  assign err_timeout = 1'b0;
`endif

  assign en_tx    = en_tx_reg;
  assign en_re    = en_re_reg;
  assign fifo_rst = fifo_rst_reg;
  assign busy     = busy_reg;
  assign done     = done_reg;
  assign aborted  = aborted_reg;
  assign shot_idx = shot_idx_reg;
  assign state    = state_reg;

endmodule

// File: doc/meas_seq_ctrl.md
# meas_seq_ctrl

Multi-shot measurement sequencer that drives the transmit and receive engines and the capture FIFO reset. One `start` pulse runs `NUM_SHOTS` back-to-back acquisitions. Each acquisition is a fixed sequence: FIFO reset window, TX phase, RE phase, then an inter-shot gap. The block sits between the key/host control logic and the TX/RE datapath, and replaces single-shot manual sequencing.

## Interface
Parameters:
- `NUM_SHOTS`, 4: acquisitions per run, 1..255.
- `RST_DLY`, 100: cycles into RST before `fifo_rst` rises.
- `RST_LEN`, 100: cycles `fifo_rst` is held high.
- `RST_TAIL`, 800: settle cycles after `fifo_rst` falls, before TX.
- `GAP_LEN`, 1000: idle cycles between shots, ≥1.
- `TIMEOUT`, 65535: maximum cycles allowed in TX or RE, 16-bit.

Ports:
- `clk_100`, in, 1: single clock.
- `rst`, in, 1: synchronous, active-high reset.
- `start`, in, 1: single-cycle run request.
- `stop`, in, 1: abort request, level-sampled.
- `tx_done`, in, 1: TX engine finished (`overTx`).
- `re_done`, in, 1: RE engine finished (`overRe`).
- `en_tx`, out, 1: TX enable.
- `en_re`, out, 1: RE enable.
- `fifo_rst`, out, 1: capture FIFO reset.
- `busy`, out, 1: high in any state except IDLE.
- `done`, out, 1: one-cycle pulse when a run completes normally.
- `aborted`, out, 1: one-cycle pulse when `stop` or a timeout ends a run.
- `err_timeout`, out, 1: sticky timeout flag.
- `shot_idx`, out, 8: index of the current shot, starting at 0.
- `state`, out, 3: state code, for debug.

## Operation
- States and codes: IDLE=0, RST=1, TX=2, RE=3, GAP=4, DONE=5. Codes 6 and 7 go to IDLE.
- A 20-bit phase counter clears on every state entry and increments every cycle while in RST, TX, RE and GAP.
- **IDLE**
  - `start`=1 and `stop`=0 → RST.
  - On that transition: `shot_idx` clears to 0 and `err_timeout` clears.
- **RST**
  - `fifo_rst`=1 while the counter is in [`RST_DLY`, `RST_DLY`+`RST_LEN`-1].
  - When the counter reaches `RST_DLY`+`RST_LEN`+`RST_TAIL`-1 → TX.
- **TX**
  - `en_tx`=1.
  - `tx_done` → RE.
- **RE**
  - `en_re`=1.
  - On `re_done`: if `shot_idx` = `NUM_SHOTS`-1 → DONE; otherwise → GAP.
- **GAP**
  - When the counter reaches `GAP_LEN`-1 → RST, and `shot_idx` increments.
- **DONE**
  - `done`=1 for exactly one cycle, then → IDLE.
- **`stop`**
  - In any non-IDLE state, `stop` has priority over every other input: next state is IDLE and `aborted` pulses.
  - In IDLE, `stop` blocks `start`.
- **Ignored inputs**
  - `start` while `busy` is ignored.
  - `tx_done` outside TX and `re_done` outside RE are ignored.
- **Simultaneous events**
  - `tx_done`/`re_done` in the same cycle as the timeout hit: the done input wins and no error is raised.
- **Reset values**: all outputs 0, state IDLE, counters 0.
- **Reset mid-run**: `rst` forces IDLE immediately. It does not pulse `done` or `aborted`.

## Timing
- Outputs are registered and computed from the next state. `en_tx`, `en_re`, `fifo_rst`, `busy` and `state` therefore change in the same cycle the state register changes.
- Latencies:
  - `start` to `busy`=1: 1 cycle.
  - `tx_done` to `en_tx`=0 and `en_re`=1: 1 cycle.
  - `stop` to all enables low: 1 cycle.
- Each RST visit lasts `RST_DLY`+`RST_LEN`+`RST_TAIL` cycles.
- Each GAP visit lasts `GAP_LEN` cycles.
- `en_tx` and `en_re` are never high in the same cycle.
- `fifo_rst` is never high while `en_tx` or `en_re` is high.

## Configuration
- Macro: `MEAS_SEQ_TIMEOUT_EN`.
- **Defined**:
  - In TX or RE, when the phase counter reaches `TIMEOUT`-1 with no done input, `err_timeout` is set (sticky), `aborted` pulses, and the next state is IDLE.
- **Undefined**:
  - The timeout logic is not built.
  - TX and RE wait indefinitely.
  - `err_timeout` is tied to 0.

## Test plan
Bench parameters for all scenarios: `NUM_SHOTS`=2, `RST_DLY`=2, `RST_LEN`=3, `RST_TAIL`=4, `GAP_LEN`=5, `TIMEOUT`=20.
- Nominal run: `start` at cycle 0; `tx_done` 6 cycles after TX entry; `re_done` 8 cycles after RE entry. Required response:
  - States follow RST(9 cycles) → TX → RE → GAP(5 cycles) → RST → TX → RE → DONE.
  - `fifo_rst` is high for 3 cycles in each RST.
  - `shot_idx` goes 0 then 1.
  - `done` pulses once, and `busy` falls the cycle after.
- Abort: `stop` during the second cycle of TX → `en_tx`=0 and state IDLE on the next edge; `aborted` pulses once; `done` never pulses.
- Timeout (macro defined): `tx_done` withheld → IDLE after 20 TX cycles; `err_timeout`=1 and stays 1; the next `start` clears it.
- Race: `tx_done` on TX cycle 19 (counter = 19) → RE entered; `err_timeout` stays 0.
- Ignored inputs: `start` pulses while busy and `re_done` asserted during TX → no state change and no effect on `shot_idx`.
- Sync reset: `rst` asserted mid-GAP → the next cycle shows all outputs 0 and state 0; no `done` or `aborted` pulse.
